// File: rtl/knn_pkg.sv
// Shared types and helpers for the KNN accelerator sequencer.
package knn_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    CLR   = 4'd1,
    LOAD  = 4'd2,
    DONE  = 4'd3,
    QUERY = 4'd4,
    START = 4'd5,
    WAIT  = 4'd6,
    READ  = 4'd7,
    DRAIN = 4'd8
  } knn_state_t;

  localparam int unsigned DIMENSIONS_DEF = 32;
  localparam int unsigned NUM_CH_DEF     = 1;
  localparam int unsigned BEATS          = DIMENSIONS_DEF / NUM_CH_DEF;

  function automatic int unsigned calc_beats(input int unsigned dims, input int unsigned ch);
    return dims / ch;
  endfunction

  function automatic logic [31:0] min32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/knn_seq_ctrl_rd_capture.sv
// Read-latency alignment pipe: tracks outstanding core reads and registers results.
module knn_rd_capture
  import knn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rd_en,
  input  logic                  rd_last,
  input  logic [31:0]           name_in,
  input  logic [DATA_WIDTH-1:0] value_in,
  output logic                  res_valid,
  output logic [31:0]           res_name,
  output logic [DATA_WIDTH-1:0] res_value,
  output logic                  res_last,
  output logic                  pipe_busy
);

  logic [READ_LATENCY-1:0] v_pipe;
  logic [READ_LATENCY-1:0] l_pipe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_pipe    <= '0;
      l_pipe    <= '0;
      res_valid <= 1'b0;
      res_last  <= 1'b0;
      res_name  <= '0;
      res_value <= '0;
    end else begin
      v_pipe[0] <= rd_en;
      l_pipe[0] <= rd_en & rd_last;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        l_pipe[i] <= l_pipe[i-1];
      end
      // The pipe tail lines up with the cycle the core drives valid data.
      res_valid <= v_pipe[READ_LATENCY-1];
      res_last  <= l_pipe[READ_LATENCY-1];
      if (v_pipe[READ_LATENCY-1]) begin
        res_name  <= name_in;
        res_value <= value_in;
      end
    end
  end

  assign pipe_busy = |v_pipe;

endmodule

// File: rtl/knn_seq_ctrl.sv
// KNN core sequencer: streams training/query vectors in, runs the core, streams k results out.
module knn_seq_ctrl
  import knn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DIMENSIONS     = 32,
  parameter int unsigned NUM_CH         = 1,
  parameter int unsigned COMPUTE_CYCLES = 64,
  parameter int unsigned READ_LATENCY   = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         cmd_go,
  input  logic [31:0]                  cfg_k,
  input  logic [31:0]                  cfg_num_train,
  output logic                         busy,
  output logic                         cfg_err,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic                         res_valid,
  output logic [31:0]                  res_name,
  output logic [DATA_WIDTH-1:0]        res_value,
  output logic                         res_last,
  output logic                         knn_reset,
  output logic                         knn_wr_en,
  output logic                         knn_rd_en,
  output logic                         knn_start,
  output logic                         knn_done,
  output logic [31:0]                  knn_k,
  output logic [NUM_CH*DATA_WIDTH-1:0] knn_data_out,
  input  logic [31:0]                  knn_name_in,
  input  logic [DATA_WIDTH-1:0]        knn_value_in
);

  localparam int unsigned NBEATS    = calc_beats(DIMENSIONS, NUM_CH);
  localparam logic [31:0] LAST_BEAT = 32'(NBEATS - 1);
  localparam logic [31:0] LAST_WAIT = 32'(COMPUTE_CYCLES - 1);

  knn_state_t  state;
  logic [31:0] num_train_q;
  logic [31:0] beat_cnt;
  logic [31:0] vec_cnt;
  logic [31:0] wait_cnt;
  logic [31:0] rd_cnt;
  logic        rd_last;
  logic        pipe_busy;
  logic        beat_acc;

  assign beat_acc = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      cfg_err      <= 1'b0;
      in_ready     <= 1'b0;
      knn_reset    <= 1'b1;
      knn_wr_en    <= 1'b0;
      knn_rd_en    <= 1'b0;
      knn_start    <= 1'b0;
      knn_done     <= 1'b0;
      knn_k        <= '0;
      knn_data_out <= '0;
      num_train_q  <= '0;
      beat_cnt     <= '0;
      vec_cnt      <= '0;
      wait_cnt     <= '0;
      rd_cnt       <= '0;
      rd_last      <= 1'b0;
    end else begin
      cfg_err   <= 1'b0;
      knn_reset <= 1'b0;
      knn_wr_en <= 1'b0;
      knn_rd_en <= 1'b0;
      knn_start <= 1'b0;
      knn_done  <= 1'b0;
      rd_last   <= 1'b0;

      // in_ready is only ever high in LOAD/QUERY, so this covers both write paths.
      if (beat_acc) begin
        knn_wr_en    <= 1'b1;
        knn_data_out <= in_data;
      end

      case (state)
        IDLE: begin
          if (cmd_go) begin
            if (cfg_k == '0 || cfg_num_train == '0) begin
              cfg_err <= 1'b1;
            end else begin
              num_train_q <= cfg_num_train;
              knn_k       <= min32(cfg_k, cfg_num_train);
              knn_reset   <= 1'b1;
              busy        <= 1'b1;
              state       <= CLR;
            end
          end
        end

        CLR: begin
          beat_cnt <= '0;
          vec_cnt  <= '0;
          in_ready <= 1'b1;
          state    <= LOAD;
        end

        LOAD: begin
          if (beat_acc) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              vec_cnt  <= vec_cnt + 32'd1;
              if (vec_cnt + 32'd1 == num_train_q) begin
                in_ready <= 1'b0;
                state    <= DONE;
              end
            end else begin
              beat_cnt <= beat_cnt + 32'd1;
            end
          end
        end

        DONE: begin
          knn_done <= 1'b1;
          in_ready <= 1'b1;
          state    <= QUERY;
        end

        QUERY: begin
          if (beat_acc) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              in_ready <= 1'b0;
              state    <= START;
            end else begin
              beat_cnt <= beat_cnt + 32'd1;
            end
          end
        end

        START: begin
          knn_start <= 1'b1;
          wait_cnt  <= '0;
          state     <= WAIT;
        end

        WAIT: begin
          // First read is issued here so rd_en lands COMPUTE_CYCLES after start.
          if (wait_cnt == LAST_WAIT) begin
            knn_rd_en <= 1'b1;
            rd_cnt    <= 32'd1;
            rd_last   <= (knn_k == 32'd1);
            state     <= READ;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end

        READ: begin
          if (rd_cnt == knn_k) begin
            state <= DRAIN;
          end else begin
            knn_rd_en <= 1'b1;
            rd_cnt    <= rd_cnt + 32'd1;
            rd_last   <= (rd_cnt + 32'd1 == knn_k);
          end
        end

        DRAIN: begin
          if (!pipe_busy) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          busy     <= 1'b0;
          in_ready <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  knn_rd_capture #(
    .DATA_WIDTH   (DATA_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_rd_capture (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_en     (knn_rd_en),
    .rd_last   (rd_last),
    .name_in   (knn_name_in),
    .value_in  (knn_value_in),
    .res_valid (res_valid),
    .res_name  (res_name),
    .res_value (res_value),
    .res_last  (res_last),
    .pipe_busy (pipe_busy)
  );

endmodule
